// File: rtl/wishbone_rr_arbiter.sv
// Round-robin Wishbone arbiter: shares one slave port between MASTER_COUNT masters,
// holding ownership for a whole m_cyc burst, with a watchdog that aborts stalled strobes.
module wishbone_rr_arbiter #(
    parameter int unsigned MASTER_COUNT   = 2,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TAG_WIDTH      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                                  sys_clk,
    input  logic                                  sys_rst,
    input  logic [MASTER_COUNT-1:0]               m_cyc,
    input  logic [MASTER_COUNT-1:0]               m_stb,
    input  logic [MASTER_COUNT-1:0]               m_we,
    input  logic [MASTER_COUNT*TAG_WIDTH-1:0]     m_tag,
    input  logic [MASTER_COUNT*(DATA_WIDTH/8)-1:0] m_sel,
    input  logic [MASTER_COUNT*ADDR_WIDTH-1:0]    m_adr,
    input  logic [MASTER_COUNT*DATA_WIDTH-1:0]    m_mosi,
    output logic [MASTER_COUNT*DATA_WIDTH-1:0]    m_miso,
    output logic [MASTER_COUNT-1:0]               m_ack,
    output logic [MASTER_COUNT-1:0]               m_err,
    output logic                                  s_cyc,
    output logic                                  s_stb,
    output logic                                  s_we,
    output logic [TAG_WIDTH-1:0]                  s_tag,
    output logic [DATA_WIDTH/8-1:0]               s_sel,
    output logic [ADDR_WIDTH-1:0]                 s_adr,
    output logic [DATA_WIDTH-1:0]                 s_mosi,
    input  logic [DATA_WIDTH-1:0]                 s_miso,
    input  logic                                  s_ack,
    input  logic                                  s_err,
    output logic [MASTER_COUNT-1:0]               grant,
    output logic                                  timeout_evt
);

    localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned IDX_WIDTH = (MASTER_COUNT > 1) ? $clog2(MASTER_COUNT) : 1;
    localparam int unsigned CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned THRESH    = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   owner_q, owner_d;
    logic [IDX_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_WIDTH-1:0]   wd_cnt_q, wd_cnt_d;
    logic                   tevt_q, tevt_d;

    logic                   own_cyc, own_stb, own_we;
    logic [TAG_WIDTH-1:0]   own_tag;
    logic [SEL_WIDTH-1:0]   own_sel;
    logic [ADDR_WIDTH-1:0]  own_adr;
    logic [DATA_WIDTH-1:0]  own_mosi;

    logic                   pick_vld;
    logic [IDX_WIDTH-1:0]   pick_idx;
    int unsigned            pick_off, best_off;
    logic [IDX_WIDTH-1:0]   next_ptr;
    logic                   stall;

    // Select the registered owner's request; non-owners never reach the slave side
    always_comb begin
        own_cyc  = 1'b0;
        own_stb  = 1'b0;
        own_we   = 1'b0;
        own_tag  = '0;
        own_sel  = '0;
        own_adr  = '0;
        own_mosi = '0;
        for (int i = 0; i < MASTER_COUNT; i++) begin
            if (owner_q == IDX_WIDTH'(i)) begin
                own_cyc  = m_cyc[i];
                own_stb  = m_stb[i];
                own_we   = m_we[i];
                own_tag  = m_tag[i*TAG_WIDTH +: TAG_WIDTH];
                own_sel  = m_sel[i*SEL_WIDTH +: SEL_WIDTH];
                own_adr  = m_adr[i*ADDR_WIDTH +: ADDR_WIDTH];
                own_mosi = m_mosi[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Lowest rotated distance from rr_ptr wins
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        pick_off = 0;
        best_off = MASTER_COUNT;
        for (int i = 0; i < MASTER_COUNT; i++) begin
            pick_off = (32'(i) + MASTER_COUNT - 32'(rr_ptr_q)) % MASTER_COUNT;
            if (m_cyc[i] && (pick_off < best_off)) begin
                best_off = pick_off;
                pick_idx = IDX_WIDTH'(i);
                pick_vld = 1'b1;
            end
        end
    end

    assign next_ptr = IDX_WIDTH'((32'(owner_q) + 32'd1) % MASTER_COUNT);
    assign stall    = (state_q == ST_BUSY) && own_stb && !s_ack && !s_err;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            wd_cnt_q <= '0;
            tevt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            wd_cnt_q <= wd_cnt_d;
            tevt_q   <= tevt_d;
        end
    end

    // Next-state: arbitration, burst release and watchdog
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        wd_cnt_d = '0;
        tevt_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    owner_d = pick_idx;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!own_cyc) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_ptr;
                end else if (stall && (TIMEOUT_CYCLES != 0)) begin
                    if (wd_cnt_q >= CNT_WIDTH'(THRESH)) begin
                        state_d = ST_ABORT;
                        tevt_d  = 1'b1;
                    end else if (wd_cnt_q != CNT_WIDTH'(TIMEOUT_CYCLES)) begin
                        wd_cnt_d = wd_cnt_q + CNT_WIDTH'(1);
                    end else begin
                        wd_cnt_d = wd_cnt_q;
                    end
                end
            end
            ST_ABORT: begin
                if (!own_cyc) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Slave-side pass-through and owner-only response routing
    always_comb begin
        s_cyc       = 1'b0;
        s_stb       = 1'b0;
        s_we        = 1'b0;
        s_tag       = '0;
        s_sel       = '0;
        s_adr       = '0;
        s_mosi      = '0;
        m_miso      = '0;
        m_ack       = '0;
        m_err       = '0;
        grant       = '0;
        timeout_evt = tevt_q;
        if (state_q == ST_BUSY) begin
            s_cyc  = own_cyc;
            s_stb  = own_stb;
            s_we   = own_we;
            s_tag  = own_tag;
            s_sel  = own_sel;
            s_adr  = own_adr;
            s_mosi = own_mosi;
        end
        for (int i = 0; i < MASTER_COUNT; i++) begin
            if (owner_q == IDX_WIDTH'(i)) begin
                if (state_q != ST_IDLE) begin
                    grant[i] = 1'b1;
                end
                if (state_q == ST_BUSY) begin
                    m_miso[i*DATA_WIDTH +: DATA_WIDTH] = s_miso;
                    m_ack[i] = s_ack;
                    m_err[i] = s_err;
                end else if (state_q == ST_ABORT) begin
                    m_err[i] = tevt_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Bench for wishbone_rr_arbiter: cycle table, hand-written corner sequences and a
// randomized run checked against a burst-level ownership model.
module tb_wishbone_rr_arbiter;

    localparam int unsigned MC = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TW = 3;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned TO = 4;

    logic            sys_clk = 1'b0;
    logic            sys_rst;
    logic [MC-1:0]   m_cyc, m_stb, m_we;
    logic [TW-1:0]   tag_a  [MC];
    logic [SW-1:0]   sel_a  [MC];
    logic [AW-1:0]   adr_a  [MC];
    logic [DW-1:0]   mosi_a [MC];
    logic [MC*TW-1:0] m_tag;
    logic [MC*SW-1:0] m_sel;
    logic [MC*AW-1:0] m_adr;
    logic [MC*DW-1:0] m_mosi;
    logic [MC*DW-1:0] m_miso;
    logic [MC-1:0]   m_ack, m_err, grant;
    logic            s_cyc, s_stb, s_we, timeout_evt;
    logic [TW-1:0]   s_tag;
    logic [SW-1:0]   s_sel;
    logic [AW-1:0]   s_adr;
    logic [DW-1:0]   s_mosi, s_miso;
    logic            s_ack, s_err;

    assign m_tag  = {tag_a[1], tag_a[0]};
    assign m_sel  = {sel_a[1], sel_a[0]};
    assign m_adr  = {adr_a[1], adr_a[0]};
    assign m_mosi = {mosi_a[1], mosi_a[0]};

    wishbone_rr_arbiter #(
        .MASTER_COUNT(MC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .TAG_WIDTH(TW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_tag(m_tag), .m_sel(m_sel),
        .m_adr(m_adr), .m_mosi(m_mosi), .m_miso(m_miso), .m_ack(m_ack), .m_err(m_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_tag(s_tag), .s_sel(s_sel),
        .s_adr(s_adr), .s_mosi(s_mosi), .s_miso(s_miso), .s_ack(s_ack), .s_err(s_err),
        .grant(grant), .timeout_evt(timeout_evt)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp_v);
        end
    endtask

    function automatic logic [73:0] s_bundle();
        return {s_cyc, s_stb, s_we, s_tag, s_sel, s_adr, s_mosi};
    endfunction

    function automatic logic [67:0] m_bundle();
        return {m_miso, m_ack, m_err};
    endfunction

    task automatic chk_zero(input string nm);
        chk({nm, " s_port"}, 128'(s_bundle()), 128'(0));
        chk({nm, " m_resp"}, 128'(m_bundle()), 128'(0));
        chk({nm, " ctl"}, 128'({grant, timeout_evt}), 128'(0));
    endtask

    typedef struct {
        logic [1:0]  cyc;
        logic [1:0]  stb;
        logic        ack;
        logic        err;
        logic [1:0]  gnt;
        logic        scyc;
        logic [31:0] adr;
        logic [1:0]  mack;
        logic [1:0]  merr;
        logic        tevt;
        logic [1:0]  mmiso;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [1:0] c, input logic [1:0] s, input logic a,
                                input logic e, input logic [1:0] g, input logic sc,
                                input logic [31:0] ad, input logic [1:0] ma,
                                input logic [1:0] me, input logic te, input logic [1:0] mm);
        vec_t v;
        v.cyc = c; v.stb = s; v.ack = a; v.err = e; v.gnt = g; v.scyc = sc;
        v.adr = ad; v.mack = ma; v.merr = me; v.tevt = te; v.mmiso = mm;
        return v;
    endfunction

    // Burst-level reference: owner (-1 = none), rotation pointer, stalled-strobe run length
    int   own, ptr, stall_run;
    logic aborted, just_ab;

    task automatic model_reset();
        own = -1; ptr = 0; stall_run = 0; aborted = 1'b0; just_ab = 1'b0;
    endtask

    task automatic model_release();
        ptr = (own + 1) % MC;
        own = -1; aborted = 1'b0; just_ab = 1'b0; stall_run = 0;
    endtask

    task automatic model_edge();
        logic ob;
        int   c;
        ob = own[0];
        if (own < 0) begin
            for (int k = 0; k < MC; k++) begin
                c = (ptr + k) % MC;
                if (own < 0 && m_cyc[c[0]]) own = c;
            end
            stall_run = 0;
        end else if (aborted) begin
            just_ab = 1'b0;
            if (!m_cyc[ob]) model_release();
        end else if (!m_cyc[ob]) begin
            model_release();
        end else if (m_stb[ob] && !s_ack && !s_err) begin
            stall_run++;
            if (stall_run >= TO) begin
                aborted = 1'b1; just_ab = 1'b1; stall_run = 0;
            end
        end else begin
            stall_run = 0;
        end
    endtask

    task automatic model_check(input int cyc_no);
        logic [73:0] es;
        logic [DW-1:0] em [MC];
        logic [1:0] eack, eerr, eg;
        logic et, ob;
        es = '0; eack = '0; eerr = '0; eg = '0; et = 1'b0;
        em[0] = '0; em[1] = '0;
        ob = own[0];
        if (own >= 0) begin
            eg[ob] = 1'b1;
            if (!aborted) begin
                es = {m_cyc[ob], m_stb[ob], m_we[ob], tag_a[ob], sel_a[ob], adr_a[ob], mosi_a[ob]};
                em[ob] = s_miso; eack[ob] = s_ack; eerr[ob] = s_err;
            end else begin
                eerr[ob] = just_ab; et = just_ab;
            end
        end
        chk($sformatf("rnd%0d s_port", cyc_no), 128'(s_bundle()), 128'(es));
        chk($sformatf("rnd%0d m_resp", cyc_no), 128'(m_bundle()), 128'({em[1], em[0], eack, eerr}));
        chk($sformatf("rnd%0d grant/tevt", cyc_no), 128'({grant, timeout_evt}), 128'({eg, et}));
    endtask

    logic [DW-1:0] exp_miso;

    initial begin
        sys_rst = 1'b0;
        m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b0; s_err = 1'b0; s_miso = 32'hDEADBEEF;
        tag_a[0] = 3'd1; tag_a[1] = 3'd6; sel_a[0] = 4'hF; sel_a[1] = 4'h3;
        adr_a[0] = 32'h1000; adr_a[1] = 32'h2000; mosi_a[0] = 32'h11111111; mosi_a[1] = 32'h22222222;

        // cyc stb ack err | grant s_cyc s_adr m_ack m_err tevt miso-mask
        tbl.push_back(mk(2'b00, 2'b00, 0, 0, 2'b00, 0, 32'h0,    2'b00, 2'b00, 0, 2'b00));
        tbl.push_back(mk(2'b01, 2'b01, 0, 0, 2'b00, 0, 32'h0,    2'b00, 2'b00, 0, 2'b00));
        tbl.push_back(mk(2'b01, 2'b01, 0, 0, 2'b01, 1, 32'h1000, 2'b00, 2'b00, 0, 2'b01));
        tbl.push_back(mk(2'b01, 2'b01, 1, 0, 2'b01, 1, 32'h1000, 2'b01, 2'b00, 0, 2'b01));
        tbl.push_back(mk(2'b00, 2'b00, 0, 0, 2'b01, 0, 32'h1000, 2'b00, 2'b00, 0, 2'b01));
        tbl.push_back(mk(2'b11, 2'b11, 0, 0, 2'b00, 0, 32'h0,    2'b00, 2'b00, 0, 2'b00));
        tbl.push_back(mk(2'b11, 2'b11, 1, 0, 2'b10, 1, 32'h2000, 2'b10, 2'b00, 0, 2'b10));
        tbl.push_back(mk(2'b01, 2'b01, 0, 0, 2'b10, 0, 32'h2000, 2'b00, 2'b00, 0, 2'b10));
        tbl.push_back(mk(2'b11, 2'b11, 0, 0, 2'b00, 0, 32'h0,    2'b00, 2'b00, 0, 2'b00));
        tbl.push_back(mk(2'b11, 2'b11, 1, 0, 2'b01, 1, 32'h1000, 2'b01, 2'b00, 0, 2'b01));
        tbl.push_back(mk(2'b10, 2'b10, 0, 0, 2'b01, 0, 32'h1000, 2'b00, 2'b00, 0, 2'b01));
        tbl.push_back(mk(2'b10, 2'b10, 0, 0, 2'b00, 0, 32'h0,    2'b00, 2'b00, 0, 2'b00));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(2'b10, 2'b10, 0, 0, 2'b10, 1, 32'h2000, 2'b00, 2'b00, 0, 2'b10));
        tbl.push_back(mk(2'b10, 2'b10, 1, 0, 2'b10, 0, 32'h0,    2'b00, 2'b10, 1, 2'b00));
        tbl.push_back(mk(2'b10, 2'b10, 1, 0, 2'b10, 0, 32'h0,    2'b00, 2'b00, 0, 2'b00));
        tbl.push_back(mk(2'b01, 2'b01, 0, 0, 2'b10, 0, 32'h0,    2'b00, 2'b00, 0, 2'b00));
        tbl.push_back(mk(2'b01, 2'b01, 0, 0, 2'b00, 0, 32'h0,    2'b00, 2'b00, 0, 2'b00));
        tbl.push_back(mk(2'b01, 2'b01, 1, 0, 2'b01, 1, 32'h1000, 2'b01, 2'b00, 0, 2'b01));
        tbl.push_back(mk(2'b00, 2'b00, 0, 0, 2'b01, 0, 32'h1000, 2'b00, 2'b00, 0, 2'b01));
        tbl.push_back(mk(2'b00, 2'b00, 0, 0, 2'b00, 0, 32'h0,    2'b00, 2'b00, 0, 2'b00));
        tbl.push_back(mk(2'b01, 2'b01, 0, 0, 2'b00, 0, 32'h0,    2'b00, 2'b00, 0, 2'b00));
        tbl.push_back(mk(2'b01, 2'b01, 0, 1, 2'b01, 1, 32'h1000, 2'b00, 2'b01, 0, 2'b01));
        tbl.push_back(mk(2'b00, 2'b00, 0, 0, 2'b01, 0, 32'h1000, 2'b00, 2'b00, 0, 2'b01));
        tbl.push_back(mk(2'b00, 2'b00, 0, 0, 2'b00, 0, 32'h0,    2'b00, 2'b00, 0, 2'b00));

        // Reset held with live requests, then ten quiet cycles after release
        repeat (3) @(posedge sys_clk);
        #1 m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1'b1;
        @(negedge sys_clk);
        chk_zero("in_reset");
        m_cyc = '0; m_stb = '0; s_ack = 1'b0;
        @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge sys_clk);
            chk_zero($sformatf("idle%0d", k));
            @(posedge sys_clk);
            #1;
        end

        for (int i = 0; i < tbl.size(); i++) begin
            m_cyc = tbl[i].cyc; m_stb = tbl[i].stb; s_ack = tbl[i].ack; s_err = tbl[i].err;
            @(negedge sys_clk);
            exp_miso = 32'hDEADBEEF;
            chk($sformatf("tbl%0d grant", i), 128'(grant), 128'(tbl[i].gnt));
            chk($sformatf("tbl%0d s_cyc", i), 128'(s_cyc), 128'(tbl[i].scyc));
            chk($sformatf("tbl%0d s_stb", i), 128'(s_stb), 128'(tbl[i].scyc));
            chk($sformatf("tbl%0d s_adr", i), 128'(s_adr), 128'(tbl[i].adr));
            chk($sformatf("tbl%0d m_ack", i), 128'(m_ack), 128'(tbl[i].mack));
            chk($sformatf("tbl%0d m_err", i), 128'(m_err), 128'(tbl[i].merr));
            chk($sformatf("tbl%0d timeout_evt", i), 128'(timeout_evt), 128'(tbl[i].tevt));
            chk($sformatf("tbl%0d m_miso", i), 128'(m_miso),
                128'({tbl[i].mmiso[1] ? exp_miso : 32'h0, tbl[i].mmiso[0] ? exp_miso : 32'h0}));
            @(posedge sys_clk);
            #1;
        end

        // Ack on the fourth stalled edge beats the watchdog and restarts its count
        m_cyc = 2'b01; m_stb = 2'b01; s_ack = 1'b0; s_err = 1'b0;
        @(posedge sys_clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            chk($sformatf("coin stall%0d s_cyc", k), 128'(s_cyc), 128'(1));
            @(posedge sys_clk);
            #1;
        end
        s_ack = 1'b1;
        @(negedge sys_clk);
        chk("coin m_ack", 128'(m_ack), 128'(2'b01));
        chk("coin m_err", 128'(m_err), 128'(0));
        chk("coin timeout_evt", 128'(timeout_evt), 128'(0));
        @(posedge sys_clk);
        #1 s_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge sys_clk);
            chk($sformatf("coin after%0d s_cyc", k), 128'(s_cyc), 128'(1));
            chk($sformatf("coin after%0d err/evt", k), 128'({m_err, timeout_evt}), 128'(0));
            @(posedge sys_clk);
            #1;
        end
        m_cyc = '0; m_stb = '0;
        @(posedge sys_clk);
        #1;
        @(negedge sys_clk);
        chk("coin released grant", 128'(grant), 128'(0));

        // Asynchronous reset while m0 owns the bus with an ack pending
        m_cyc = 2'b01; m_stb = 2'b01;
        @(posedge sys_clk);
        #1;
        @(negedge sys_clk);
        chk("rst owner grant", 128'(grant), 128'(2'b01));
        s_ack = 1'b1;
        #2 sys_rst = 1'b0;
        #1;
        chk("rst s_cyc", 128'(s_cyc), 128'(0));
        chk("rst grant", 128'(grant), 128'(0));
        chk("rst m_ack", 128'(m_ack), 128'(0));
        m_cyc = 2'b10; m_stb = 2'b10; s_ack = 1'b0;
        @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        @(negedge sys_clk);
        chk("rst idle grant", 128'(grant), 128'(0));
        @(posedge sys_clk);
        #1;
        @(negedge sys_clk);
        chk("rst m1 grant", 128'(grant), 128'(2'b10));
        chk("rst m1 s_adr", 128'(s_adr), 128'(32'h2000));

        // Randomized traffic against the reference model from a fresh reset
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        m_cyc = '0; m_stb = '0;
        model_reset();
        @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < MC; i++) begin
                if (m_cyc[i]) begin
                    if ($urandom_range(0, 99) < 15) m_cyc[i] = 1'b0;
                end else if ($urandom_range(0, 99) < 30) begin
                    m_cyc[i] = 1'b1;
                end
                m_stb[i]  = m_cyc[i] && ($urandom_range(0, 99) < 70);
                m_we[i]   = 1'($urandom);
                tag_a[i]  = TW'($urandom);
                sel_a[i]  = SW'($urandom);
                adr_a[i]  = $urandom;
                mosi_a[i] = $urandom;
            end
            s_miso = $urandom;
            s_ack  = ($urandom_range(0, 99) < 35);
            s_err  = !s_ack && ($urandom_range(0, 99) < 5);
            @(negedge sys_clk);
            model_check(n);
            @(posedge sys_clk);
            model_edge();
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wishbone_rr_arbiter.md
Name: wishbone_rr_arbiter

Overview:
- Shares one Wishbone slave port (typically a crossbar slave leg or a peripheral bus) between MASTER_COUNT masters.
- Uses registered round-robin arbitration, with ownership held for the whole m_cyc burst.
- A bus watchdog aborts any transfer the slave never acknowledges and returns m_err to the owning master.
- Sits between CPU/DMA master ports and a single shared bus segment.

Parameters:
- MASTER_COUNT, 2, number of masters; legal range is 1 to 16.
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; must be a multiple of 8.
- TAG_WIDTH, 3, tag width.
- TIMEOUT_CYCLES, 255, stalled-strobe cycles before an abort; 0 disables the watchdog.

Ports:
- sys_clk  in  1  system clock; all state changes on its rising edge.
- sys_rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- m_cyc  in  MASTER_COUNT  per-master cycle request.
- m_stb  in  MASTER_COUNT  per-master strobe.
- m_we  in  MASTER_COUNT  per-master write enable.
- m_tag  in  MASTER_COUNT*TAG_WIDTH  per-master tag.
- m_sel  in  MASTER_COUNT*DATA_WIDTH/8  per-master byte selects.
- m_adr  in  MASTER_COUNT*ADDR_WIDTH  per-master address.
- m_mosi  in  MASTER_COUNT*DATA_WIDTH  per-master write data.
- m_miso  out  MASTER_COUNT*DATA_WIDTH  per-master read data.
- m_ack  out  MASTER_COUNT  per-master acknowledge.
- m_err  out  MASTER_COUNT  per-master error.
- s_cyc, s_stb, s_we, s_tag, s_sel, s_adr, s_mosi  out  1, 1, 1, TAG_WIDTH, DATA_WIDTH/8, ADDR_WIDTH, DATA_WIDTH  shared slave port.
- s_miso  in  DATA_WIDTH  slave read data.
- s_ack  in  1  slave acknowledge.
- s_err  in  1  slave error.
- grant  out  MASTER_COUNT  one-hot current owner; all zero when there is no owner.
- timeout_evt  out  1  one-cycle pulse on each watchdog abort.

Behaviour:
- Reset (sys_rst=0, asynchronous) sets:
  - state=IDLE, rr_ptr=0, owner=0, watchdog count=0.
  - grant=0, timeout_evt=0.
  - All s_* outputs 0; all m_miso/m_ack/m_err outputs 0.
- Reset mid-transfer drops s_cyc immediately; no ack or err is delivered.
- States: IDLE, BUSY, ABORT.

IDLE:
- s_* outputs are all 0; m_ack=m_err=0; m_miso=0.
- If any m_cyc is high at a clock edge, pick the first requester in search order rr_ptr, rr_ptr+1, … modulo MASTER_COUNT.
- Register it as owner and enter BUSY.
- Arbitration latency is 1 cycle from m_cyc to s_cyc.
- With no requests, remain in IDLE.

BUSY:
- s_cyc/s_stb/s_we/s_tag/s_sel/s_adr/s_mosi equal the owner's inputs combinationally.
- The owner's m_miso/m_ack/m_err equal s_miso/s_ack/s_err combinationally.
- Every non-owner sees m_ack=0, m_err=0, m_miso=0, whatever it requests.
- grant[owner]=1.
- Pipelined multi-beat transfers pass through unchanged; ownership holds while owner m_cyc=1.
- Release: an edge that samples owner m_cyc=0 causes:
  - state goes to IDLE;
  - rr_ptr = (owner+1) mod MASTER_COUNT.
  - s_cyc already follows m_cyc low combinationally in that cycle.
  - At least one IDLE cycle separates consecutive owners.

Watchdog (TIMEOUT_CYCLES>0, BUSY only):
- Count increments on each edge with s_stb=1 and s_ack=0 and s_err=0.
- Count clears on any ack/err, or when s_stb=0.
- Count width is clog2(TIMEOUT_CYCLES+1) and the counter saturates; it never wraps.
- When the count reaches TIMEOUT_CYCLES and no ack/err is present that cycle, the next state is ABORT.
- If ack/err coincides with the threshold cycle, the ack/err wins: normal transfer, count clears.

ABORT:
- s_cyc=s_stb=0; other s_* outputs 0. s_ack/s_err/s_miso are ignored.
- In the first ABORT cycle: owner m_err=1 and timeout_evt=1; both are 0 afterwards.
- Stay in ABORT while owner m_cyc=1.
- On an edge with owner m_cyc=0, go to IDLE with rr_ptr = owner+1 mod MASTER_COUNT.

General:
- MASTER_COUNT=1: arbitration degenerates to a pass-through with a 1-cycle grant latency; rr_ptr is constant 0.
- No combinational path exists from any non-owner input to any output.

Test Plan:
- Reset and idle: hold sys_rst=0, then release with m_cyc=0 → all outputs 0, grant=0 for 10 cycles.
- Single read: m0 cyc/stb, adr=0x1000, slave acks with s_miso=0xDEADBEEF 2 cycles later → grant=01 one cycle after m_cyc; m_ack[0]=1 with m_miso[0]=0xDEADBEEF; m_ack[1]=0.
- Round-robin fairness: both masters hold m_cyc continuously, each dropping m_cyc after one acked beat → grant sequence 01, 10, 01, 10 with one idle cycle between grants.
- Timeout: TIMEOUT_CYCLES=4, m1 strobes and the slave never acks →
  - s_cyc falls after 4 stalled cycles;
  - m_err[1] and timeout_evt each pulse for exactly one cycle;
  - s_ack asserted afterwards is not forwarded;
  - after m1 drops cyc, the next grant goes to m0.
- Coincident threshold: TIMEOUT_CYCLES=4, slave acks on the 4th stalled edge → m_ack pulses, m_err=0, timeout_evt=0.
- Reset mid-burst: assert sys_rst=0 while m0 is owner with an ack pending → s_cyc=0 asynchronously, grant=0; after release, m1 requesting alone is granted first.
